// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two requester channels and the sink channel of mux2_rr_arbiter.
// The trunc signal exists only when ARB_MAXBURST_EN is defined.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             last_a;
    logic             ready_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             last_b;
    logic             ready_b;
    logic             sel;
    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       beat_cnt;
`ifdef ARB_MAXBURST_EN
    logic             trunc;
`endif

    modport master (
        output req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
        input  ready_a, ready_b, sel, grant_a, grant_b, out_data, out_valid, beat_cnt
`ifdef ARB_MAXBURST_EN
        , input trunc
`endif
    );

    modport slave (
        input  req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
        output ready_a, ready_b, sel, grant_a, grant_b, out_data, out_valid, beat_cnt
`ifdef ARB_MAXBURST_EN
        , output trunc
`endif
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter driving the select of a shared 2:1 mux toward one sink.
// Define ARB_MAXBURST_EN to force-release a grant after MAX_BURST beats without last.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    mux2_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be within 1..255");
    end

    state_e     state_q, state_d;
    logic       rr_q, rr_d;
    logic       sel_q, grant_a_q, grant_b_q;
    logic [7:0] beat_cnt_q, beat_cnt_d, cnt_inc;
    logic       own_req, own_last, oth_req;
    logic       out_valid, xfer, rel, forced;

    // Handshake: a beat moves only when out_valid and out_ready are both high;
    // the granted side sees ready in that same cycle, the other side never does.
    always_comb begin
        own_req   = (state_q == GNT_B) ? bus.req_b  : bus.req_a;
        own_last  = (state_q == GNT_B) ? bus.last_b : bus.last_a;
        oth_req   = (state_q == GNT_B) ? bus.req_a  : bus.req_b;
        out_valid = !rst && ((grant_a_q && bus.req_a) || (grant_b_q && bus.req_b));
        xfer      = out_valid && bus.out_ready;
        cnt_inc   = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
    end

    assign bus.out_valid = out_valid;
    assign bus.ready_a   = xfer && grant_a_q;
    assign bus.ready_b   = xfer && grant_b_q;
    assign bus.sel       = sel_q;
    assign bus.grant_a   = grant_a_q;
    assign bus.grant_b   = grant_b_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.out_data  = grant_a_q ? bus.data_a : (grant_b_q ? bus.data_b : '0);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        rel        = 1'b0;
        forced     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) state_d = rr_q ? GNT_B : GNT_A;
                else if (bus.req_a)         state_d = GNT_A;
                else if (bus.req_b)         state_d = GNT_B;
            end
            GNT_A, GNT_B: begin
                if (xfer) begin
                    beat_cnt_d = cnt_inc;
`ifdef ARB_MAXBURST_EN
                    forced = !own_last && (cnt_inc == 8'(MAX_BURST));
`endif
                    rel = own_last || forced;
                end
                // Release hands over with no bubble; the other side wins a tie.
                if (rel) begin
                    beat_cnt_d = 8'd0;
                    rr_d       = (state_q == GNT_A);
                    if (oth_req)      state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                    else if (own_req) state_d = state_q;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_MAXBURST_EN
    logic trunc_q;
    always_ff @(posedge clk) begin
        if (rst) trunc_q <= 1'b0;
        else     trunc_q <= forced;
    end
    assign bus.trunc = trunc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            sel_q      <= 1'b0;
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            sel_q      <= (state_d == GNT_B);
            grant_a_q  <= (state_d == GNT_A);
            grant_b_q  <= (state_d == GNT_B);
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus random traffic, checked against
// an ownership-level reference model and a beat scoreboard.
module tb_mux2_rr_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model: who owns the path, who wins a tie ----------------
    int m_owner  = 0;   // 0 none, 1 A, 2 B
    int m_prefer = 1;   // side that wins when both request from idle
    int m_beats  = 0;
    bit m_trunc  = 0;

    always @(negedge clk) begin
        int own_req, own_last, oth_req, nb;
        logic [WIDTH-1:0] own_data, exp_data;
        bit exp_valid, xfer, done, forced;
        if (rst) begin
            m_owner = 0; m_prefer = 1; m_beats = 0; m_trunc = 0;
            check("rst_ready_a", 32'(bus.ready_a), 0);
            check("rst_ready_b", 32'(bus.ready_b), 0);
            check("rst_out_valid", 32'(bus.out_valid), 0);
        end else begin
            own_req  = (m_owner == 2) ? int'(bus.req_b) : int'(bus.req_a);
            own_last = (m_owner == 2) ? int'(bus.last_b) : int'(bus.last_a);
            oth_req  = (m_owner == 2) ? int'(bus.req_a) : int'(bus.req_b);
            own_data = (m_owner == 2) ? bus.data_b : bus.data_a;
            exp_valid = (m_owner != 0) && (own_req != 0);
            exp_data  = (m_owner == 0) ? '0 : own_data;
            xfer = exp_valid && bus.out_ready;
            check("grant_a", 32'(bus.grant_a), 32'(m_owner == 1));
            check("grant_b", 32'(bus.grant_b), 32'(m_owner == 2));
            check("sel", 32'(bus.sel), 32'(m_owner == 2));
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("ready_a", 32'(bus.ready_a), 32'(xfer && m_owner == 1));
            check("ready_b", 32'(bus.ready_b), 32'(xfer && m_owner == 2));
            check("out_data", 32'(bus.out_data), 32'(exp_data));
            check("beat_cnt", 32'(bus.beat_cnt), 32'(m_beats));
`ifdef ARB_MAXBURST_EN
            check("trunc", 32'(bus.trunc), 32'(m_trunc));
`endif
            m_trunc = 0;
            if (xfer) begin
                exp_q.push_back({m_owner == 2, own_data});
                nb = (m_beats < 255) ? m_beats + 1 : 255;
                forced = 0;
`ifdef ARB_MAXBURST_EN
                forced = (own_last == 0) && (nb == MAX_BURST);
`endif
                done = (own_last != 0) || forced;
                m_beats = nb;
                if (done) begin
                    m_trunc  = forced;
                    m_beats  = 0;
                    m_prefer = 3 - m_owner;
                    if (oth_req != 0)      m_owner = 3 - m_owner;
                    else if (own_req == 0) m_owner = 0;
                end
            end else if (m_owner == 0) begin
                if (bus.req_a && bus.req_b) m_owner = m_prefer;
                else if (bus.req_a)         m_owner = 1;
                else if (bus.req_b)         m_owner = 2;
            end
        end
    end

    // ---------------- monitor: every accepted beat must match the scoreboard ----------------
    always @(negedge clk) begin
        logic [WIDTH:0] item;
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got %0h expected none at %0t", {bus.sel, bus.out_data}, $time);
            end else begin
                item = exp_q.pop_front();
                check("beat", 32'({bus.sel, bus.out_data}), 32'(item));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ra, input logic [WIDTH-1:0] da, input logic la,
                         input logic rb, input logic [WIDTH-1:0] db, input logic lb,
                         input logic ordy);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_a = ra; bus.data_a = da; bus.last_a = la;
        bus.req_b = rb; bus.data_b = db; bus.last_b = lb;
        bus.out_ready = ordy;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.last_a = 0; bus.last_b = 0;
        bus.data_a = 0; bus.data_b = 0; bus.out_ready = 0;
        repeat (cycles - 1) @(posedge clk);
    endtask

    initial begin
        bus.req_a = 0; bus.req_b = 0; bus.last_a = 0; bus.last_b = 0;
        bus.data_a = 0; bus.data_b = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);

        // lone requester, then a tie that must go to B
        drive(1, 8'h3C, 1, 0, 8'h00, 0, 1);
        drive(1, 8'h3C, 1, 0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        drive(1, 8'h01, 1, 1, 8'h02, 1, 1);
        drive(0, 8'h00, 0, 1, 8'h02, 1, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // contention from reset: single-beat packets on both sides
        apply_reset(1);
        for (int i = 0; i < 8; i++) drive(1, 8'hA0 + 8'(i), 1, 1, 8'hB0 + 8'(i), 1, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // backpressure inside a 3-beat B packet
        apply_reset(1);
        drive(0, 8'h00, 0, 1, 8'h11, 0, 1);
        drive(0, 8'h00, 0, 1, 8'h11, 0, 1);
        drive(0, 8'h00, 0, 1, 8'h22, 0, 0);
        drive(0, 8'h00, 0, 1, 8'h22, 0, 0);
        drive(0, 8'h00, 0, 1, 8'h22, 0, 1);
        drive(0, 8'h00, 0, 1, 8'h33, 1, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // mid-packet request drop by A while B waits
        apply_reset(1);
        drive(1, 8'h51, 0, 0, 8'h00, 0, 1);
        drive(1, 8'h51, 0, 1, 8'h61, 1, 1);
        repeat (3) drive(0, 8'h00, 0, 1, 8'h61, 1, 1);
        drive(1, 8'h52, 0, 1, 8'h61, 1, 1);
        drive(1, 8'h53, 1, 1, 8'h61, 1, 1);
        drive(0, 8'h00, 0, 1, 8'h61, 1, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // reset in the middle of an A packet
        apply_reset(1);
        drive(1, 8'h71, 0, 0, 8'h00, 0, 1);
        drive(1, 8'h71, 0, 0, 8'h00, 0, 1);
        drive(1, 8'h72, 0, 0, 8'h00, 0, 1);
        @(posedge clk); #1; rst = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // long A burst without last while B waits (force-release when enabled)
        apply_reset(1);
        for (int i = 0; i < 6; i++) drive(1, 8'hC0 + 8'(i), 0, 1, 8'hD0, 1, 1);
        for (int i = 0; i < 6; i++) drive(1, 8'hC6 + 8'(i), 0, 0, 8'h00, 0, 1);
        drive(1, 8'hCF, 1, 0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // beat counter saturation on a very long packet
        apply_reset(1);
        for (int i = 0; i < 262; i++) drive(1, 8'(i), 0, 0, 8'h00, 0, 1);
        drive(1, 8'hEE, 1, 0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // random traffic with occasional resets
        apply_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset(1);
            end else begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) != 0);
            end
        end
        repeat (3) drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk); #4;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
